// File: rtl/approx_metrics_pkg.sv
// Shared defaults, state encoding and reference limits for the approximate-adder
// error-metric accumulator.
package approx_metrics_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 2 * DEF_WIDTH + 1;
    localparam int unsigned DEF_ACC_W = 2 * DEF_WIDTH + 4 + DEF_CNT_W;
    localparam int unsigned MAX_ERR   = (2 ** (DEF_WIDTH + 1)) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/approx_err_stage.sv
// Combinational per-beat compute: exact sum, signed error of the approximate sum,
// its magnitude and a nonzero flag.
module approx_err_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_approx,
    output logic [WIDTH+1:0] err,
    output logic [WIDTH+1:0] abs_err,
    output logic             nonzero
);

    logic [WIDTH:0]   exact;
    logic [WIDTH+1:0] exact_x;
    logic [WIDTH+1:0] approx_x;

    always_comb begin
        exact    = {1'b0, in_a} + {1'b0, in_b};
        exact_x  = {1'b0, exact};
        approx_x = {1'b0, in_approx};
        // Both operands are non-negative and one bit narrower, so the difference never overflows.
        err      = approx_x - exact_x;
        abs_err  = err[WIDTH+1] ? ((WIDTH+2)'(0) - err) : err;
        nonzero  = |err;
    end

endmodule

// File: rtl/approx_err_accum.sv
// Streaming error-metric accumulator: counts and sums signed, absolute and squared
// error of an approximate adder through a two-stage, non-stalling pipeline.
module approx_err_accum
    import approx_metrics_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = 2 * WIDTH + 1,
    parameter int unsigned ACC_W = 2 * WIDTH + 4 + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] err_sum,
    output logic [ACC_W-1:0] abs_err_sum,
    output logic [ACC_W-1:0] sq_err_sum,
    output logic [WIDTH+1:0] max_abs_err,
    output logic             overflow
);

    localparam int unsigned E_W  = WIDTH + 2;
    localparam int unsigned SQ_W = 2 * WIDTH + 4;

    state_t           state;
    logic [CNT_W-1:0] ns_q;
    logic [CNT_W-1:0] accepted;
    logic             accept;

    logic [E_W-1:0]   st_err;
    logic [E_W-1:0]   st_abs;
    logic             st_nz;

    logic             v1, v2;
    logic [E_W-1:0]   err1, abs1, err2, abs2;
    logic             nz1, nz2;
    logic [SQ_W-1:0]  sq2;

    logic [CNT_W-1:0] cnt_nx;
    logic             cnt_c;
    logic [ACC_W-1:0] err_ext, err_nx;
    logic             err_ovf;
    logic [ACC_W-1:0] abs_nx, sq_nx;
    logic             abs_c, sq_c;

    assign in_ready = (state == RUN) && (accepted < ns_q);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    // A restart edge discards any beat presented alongside it.
    assign accept   = in_valid && in_ready && !start;

    approx_err_stage #(.WIDTH(WIDTH)) u_stage (
        .in_a      (in_a),
        .in_b      (in_b),
        .in_approx (in_approx),
        .err       (st_err),
        .abs_err   (st_abs),
        .nonzero   (st_nz)
    );

    always_comb begin
        {cnt_c, cnt_nx} = {1'b0, err_count} + (CNT_W + 1)'(nz2);
        err_ext         = {{(ACC_W - E_W){err2[E_W-1]}}, err2};
        err_nx          = err_sum + err_ext;
        err_ovf         = (err_sum[ACC_W-1] == err_ext[ACC_W-1]) &&
                          (err_nx[ACC_W-1] != err_sum[ACC_W-1]);
        {abs_c, abs_nx} = {1'b0, abs_err_sum} + (ACC_W + 1)'(abs2);
        {sq_c, sq_nx}   = {1'b0, sq_err_sum} + (ACC_W + 1)'(sq2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ns_q     <= '0;
            accepted <= '0;
        end else if (start) begin
            state    <= RUN;
            ns_q     <= num_samples;
            accepted <= '0;
        end else begin
            if (accept)
                accepted <= accepted + CNT_W'(1);
            case (state)
                RUN:     if (accepted == ns_q) state <= DRAIN;
                DRAIN:   if (!v1 && !v2) state <= DONE;
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0;
            err1 <= '0; abs1 <= '0; nz1 <= 1'b0;
            err2 <= '0; abs2 <= '0; nz2 <= 1'b0; sq2 <= '0;
            err_count <= '0; err_sum <= '0; abs_err_sum <= '0; sq_err_sum <= '0;
            max_abs_err <= '0; overflow <= 1'b0;
        end else if (start) begin
            v1 <= 1'b0; v2 <= 1'b0;
            err1 <= '0; abs1 <= '0; nz1 <= 1'b0;
            err2 <= '0; abs2 <= '0; nz2 <= 1'b0; sq2 <= '0;
            err_count <= '0; err_sum <= '0; abs_err_sum <= '0; sq_err_sum <= '0;
            max_abs_err <= '0; overflow <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                err1 <= st_err;
                abs1 <= st_abs;
                nz1  <= st_nz;
            end
            v2 <= v1;
            if (v1) begin
                err2 <= err1;
                abs2 <= abs1;
                nz2  <= nz1;
                sq2  <= SQ_W'(abs1) * SQ_W'(abs1);
            end
            if (v2) begin
                err_count   <= cnt_nx;
                err_sum     <= err_nx;
                abs_err_sum <= abs_nx;
                sq_err_sum  <= sq_nx;
                if (abs2 > max_abs_err)
                    max_abs_err <= abs2;
                if (cnt_c || err_ovf || abs_c || sq_c)
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_approx_err_accum.sv
// Directed self-checking bench for approx_err_accum with hand-computed metrics.
module tb_approx_err_accum;
    import approx_metrics_pkg::*;

    localparam int unsigned W  = DEF_WIDTH;
    localparam int unsigned CW = DEF_CNT_W;
    localparam int unsigned AW = DEF_ACC_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_samples;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [W:0]    in_approx;
    logic          busy, done;
    logic [CW-1:0] err_count;
    logic [AW-1:0] err_sum, abs_err_sum, sq_err_sum;
    logic [W+1:0]  max_abs_err;
    logic          overflow;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    approx_err_accum #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_approx   (in_approx),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .err_sum     (err_sum),
        .abs_err_sum (abs_err_sum),
        .sq_err_sum  (sq_err_sum),
        .max_abs_err (max_abs_err),
        .overflow    (overflow)
    );

    task automatic pulse_start(input logic [CW-1:0] n);
        start = 1'b1;
        num_samples = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W:0] ap, output bit ok);
        in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = done;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(posedge clk); #1;
            ok = done;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_approx = '0;
        #2;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %0b expected 0", done); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
        compared++; if (err_count !== '0) begin mismatched++; $display("FAIL rst_err_count: got %0d expected 0", err_count); end
        compared++; if (sq_err_sum !== '0) begin mismatched++; $display("FAIL rst_sq: got %0d expected 0", sq_err_sum); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exact_exhaustive;
        bit ok;
        int n_ok = 0;
        logic [W:0] s;
        pulse_start(CW'(65536));
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                s = W'(a) + W'(b) + (W + 1)'(0);
                s = {1'b0, W'(a)} + {1'b0, W'(b)};
                send_beat(W'(a), W'(b), s, ok);
                if (ok) n_ok++;
            end
        end
        compared++; if (n_ok !== 65536) begin mismatched++; $display("FAIL t1_accepted: got %0d expected 65536", n_ok); end
        wait_done(20, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL t1_done: got %0b expected 1", ok); end
        compared++; if (err_count !== '0) begin mismatched++; $display("FAIL t1_err_count: got %0d expected 0", err_count); end
        compared++; if (err_sum !== '0) begin mismatched++; $display("FAIL t1_err_sum: got %0d expected 0", err_sum); end
        compared++; if (abs_err_sum !== '0) begin mismatched++; $display("FAIL t1_abs: got %0d expected 0", abs_err_sum); end
        compared++; if (sq_err_sum !== '0) begin mismatched++; $display("FAIL t1_sq: got %0d expected 0", sq_err_sum); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL t1_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_offset_latency;
        bit ok;
        pulse_start(CW'(4));
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL t2_busy: got %0b expected 1", busy); end
        send_beat(8'd1, 8'd2, 9'd4, ok);
        compared++; if (err_count !== CW'(0)) begin mismatched++; $display("FAIL t2_lat0: got %0d expected 0", err_count); end
        send_beat(8'd10, 8'd20, 9'd31, ok);
        compared++; if (err_count !== CW'(0)) begin mismatched++; $display("FAIL t2_lat1: got %0d expected 0", err_count); end
        send_beat(8'd100, 8'd100, 9'd201, ok);
        compared++; if (err_count !== CW'(1)) begin mismatched++; $display("FAIL t2_lat2: got %0d expected 1", err_count); end
        send_beat(8'd255, 8'd255, 9'd511, ok);
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL t2_ready_full: got %0b expected 0", in_ready); end
        wait_done(20, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL t2_done: got %0b expected 1", ok); end
        compared++; if (err_count !== CW'(4)) begin mismatched++; $display("FAIL t2_err_count: got %0d expected 4", err_count); end
        compared++; if (err_sum !== AW'(4)) begin mismatched++; $display("FAIL t2_err_sum: got %0d expected 4", err_sum); end
        compared++; if (abs_err_sum !== AW'(4)) begin mismatched++; $display("FAIL t2_abs: got %0d expected 4", abs_err_sum); end
        compared++; if (sq_err_sum !== AW'(4)) begin mismatched++; $display("FAIL t2_sq: got %0d expected 4", sq_err_sum); end
        compared++; if (max_abs_err !== (W + 2)'(1)) begin mismatched++; $display("FAIL t2_max: got %0d expected 1", max_abs_err); end
    endtask

    task automatic test_extremes;
        bit ok;
        logic [AW-1:0] neg510;
        neg510 = '0;
        neg510 = neg510 - AW'(510);
        pulse_start(CW'(2));
        send_beat(8'd255, 8'd255, 9'd0, ok);
        send_beat(8'd0, 8'd0, 9'd511, ok);
        idle_cycles(1);
        compared++; if (err_sum !== neg510) begin mismatched++; $display("FAIL t3_err_sum_neg: got %0h expected %0h", err_sum, neg510); end
        compared++; if (abs_err_sum !== AW'(510)) begin mismatched++; $display("FAIL t3_abs_mid: got %0d expected 510", abs_err_sum); end
        wait_done(20, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL t3_done: got %0b expected 1", ok); end
        compared++; if (err_count !== CW'(2)) begin mismatched++; $display("FAIL t3_err_count: got %0d expected 2", err_count); end
        compared++; if (err_sum !== AW'(1)) begin mismatched++; $display("FAIL t3_err_sum: got %0d expected 1", err_sum); end
        compared++; if (abs_err_sum !== AW'(1021)) begin mismatched++; $display("FAIL t3_abs: got %0d expected 1021", abs_err_sum); end
        compared++; if (sq_err_sum !== AW'(521221)) begin mismatched++; $display("FAIL t3_sq: got %0d expected 521221", sq_err_sum); end
        compared++; if (max_abs_err !== (W + 2)'(MAX_ERR)) begin mismatched++; $display("FAIL t3_max: got %0d expected %0d", max_abs_err, MAX_ERR); end
    endtask

    task automatic test_zero_samples;
        in_valid = 1'b1; in_a = 8'd0; in_b = 8'd0; in_approx = 9'd7;
        start = 1'b1; num_samples = '0;
        @(posedge clk); #1;
        start = 1'b0;
        compared++; if (busy !== 1'b1 || done !== 1'b0) begin mismatched++; $display("FAIL t4_e1_state: got busy=%0b done=%0b expected busy=1 done=0", busy, done); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL t4_e1_ready: got %0b expected 0", in_ready); end
        compared++; if (sq_err_sum !== '0) begin mismatched++; $display("FAIL t4_cleared_sq: got %0d expected 0", sq_err_sum); end
        @(posedge clk); #1;
        compared++; if (busy !== 1'b1 || done !== 1'b0) begin mismatched++; $display("FAIL t4_e2_state: got busy=%0b done=%0b expected busy=1 done=0", busy, done); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL t4_e2_ready: got %0b expected 0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        compared++; if (done !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL t4_e3_done: got done=%0b busy=%0b expected done=1 busy=0", done, busy); end
        compared++; if (err_count !== '0 || abs_err_sum !== '0 || max_abs_err !== '0) begin mismatched++; $display("FAIL t4_metrics: got cnt=%0d abs=%0d max=%0d expected 0", err_count, abs_err_sum, max_abs_err); end
    endtask

    task automatic test_gapped_restart;
        bit ok;
        pulse_start(CW'(8));
        for (int i = 0; i < 5; i++) begin
            send_beat(8'd1, 8'd1, 9'd5, ok);
            if (i < 4) idle_cycles(2);
        end
        compared++; if (err_count !== CW'(4)) begin mismatched++; $display("FAIL t5_pre_count: got %0d expected 4", err_count); end
        start = 1'b1; num_samples = CW'(3);
        in_valid = 1'b1; in_a = 8'd0; in_b = 8'd0; in_approx = 9'd511;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        compared++; if (err_count !== '0 || err_sum !== '0) begin mismatched++; $display("FAIL t5_cleared: got cnt=%0d sum=%0d expected 0", err_count, err_sum); end
        send_beat(8'd5, 8'd5, 9'd8, ok);
        idle_cycles(2);
        send_beat(8'd3, 8'd4, 9'd7, ok);
        idle_cycles(2);
        send_beat(8'd7, 8'd0, 9'd12, ok);
        wait_done(20, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL t5_done: got %0b expected 1", ok); end
        compared++; if (err_count !== CW'(2)) begin mismatched++; $display("FAIL t5_err_count: got %0d expected 2", err_count); end
        compared++; if (err_sum !== AW'(3)) begin mismatched++; $display("FAIL t5_err_sum: got %0d expected 3", err_sum); end
        compared++; if (abs_err_sum !== AW'(7)) begin mismatched++; $display("FAIL t5_abs: got %0d expected 7", abs_err_sum); end
        compared++; if (sq_err_sum !== AW'(29)) begin mismatched++; $display("FAIL t5_sq: got %0d expected 29", sq_err_sum); end
        compared++; if (max_abs_err !== (W + 2)'(5)) begin mismatched++; $display("FAIL t5_max: got %0d expected 5", max_abs_err); end
    endtask

    task automatic test_reset_midrun;
        bit ok;
        pulse_start(CW'(10));
        send_beat(8'd2, 8'd2, 9'd5, ok);
        send_beat(8'd2, 8'd2, 9'd5, ok);
        send_beat(8'd2, 8'd2, 9'd5, ok);
        compared++; if (err_count !== CW'(1)) begin mismatched++; $display("FAIL t6_pre_count: got %0d expected 1", err_count); end
        rst_n = 1'b0;
        #1;
        compared++; if (err_count !== '0 || err_sum !== '0 || abs_err_sum !== '0) begin mismatched++; $display("FAIL t6_rst_metrics: got cnt=%0d sum=%0d abs=%0d expected 0", err_count, err_sum, abs_err_sum); end
        compared++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin mismatched++; $display("FAIL t6_rst_ctrl: got busy=%0b done=%0b ready=%0b expected 0", busy, done, in_ready); end
        compared++; if (max_abs_err !== '0) begin mismatched++; $display("FAIL t6_rst_max: got %0d expected 0", max_abs_err); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start(CW'(1));
        send_beat(8'd1, 8'd1, 9'd3, ok);
        wait_done(20, ok);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL t6_done: got %0b expected 1", ok); end
        compared++; if (err_count !== CW'(1) || err_sum !== AW'(1) || sq_err_sum !== AW'(1)) begin mismatched++; $display("FAIL t6_post: got cnt=%0d sum=%0d sq=%0d expected 1/1/1", err_count, err_sum, sq_err_sum); end
    endtask

    initial begin
        test_reset;
        test_exact_exhaustive;
        test_offset_latency;
        test_extremes;
        test_zero_samples;
        test_gapped_restart;
        test_reset_midrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
